// File: rtl/rv_pkg.sv
// rv_pkg: RV32I opcodes, instruction formats and encoder FSM states shared by decoder and encoder.
package rv_pkg;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [31:0] EBREAK_WORD = 32'h0010_0073;
  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD} fmt_e;
  typedef enum logic [1:0] {IDLE, RUN, TERM, DONE} state_e;
  function automatic fmt_e fmt_of(input logic [6:0] op);
    case (op)
      OP_OP: return FMT_R;
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM, OP_FENCE: return FMT_I;
      OP_STORE: return FMT_S;
      OP_BRANCH: return FMT_B;
      OP_LUI, OP_AUIPC: return FMT_U;
      OP_JAL: return FMT_J;
      default: return FMT_BAD;
    endcase
  endfunction
endpackage

// File: rtl/inst_pack.sv
// inst_pack: combinational packing of decoded RV32I fields into one instruction word.
module inst_pack import rv_pkg::*; (
  input  logic [6:0]  op,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        fmt_bad
);
  fmt_e fmt;
  logic shamt;
  always_comb begin
    fmt = fmt_of(op);
    // slli/srli/srai carry funct7 in the upper bits and a 5-bit shift amount
    shamt = op == OP_IMM && funct3[1:0] == 2'b01;
    case (fmt)
      FMT_R: word = {funct7, rs2, rs1, funct3, rd, op};
      FMT_I: word = shamt ? {funct7, imm[4:0], rs1, funct3, rd, op} : {imm[11:0], rs1, funct3, rd, op};
      FMT_S: word = {imm[11:5], rs2, rs1, funct3, imm[4:0], op};
      FMT_B: word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op};
      FMT_U: word = {imm[31:12], rd, op};
      FMT_J: word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
      default: word = '0;
    endcase
    fmt_bad = fmt == FMT_BAD;
  end
endmodule

// File: rtl/inst_stream_encoder.sv
// inst_stream_encoder: streams encoded RV32I words to instruction memory and closes each program with EBREAK.
module inst_stream_encoder import rv_pkg::*; #(
  parameter int MEM_WORDS = 1024,
  parameter int AW = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [AW-1:0]              base,
  input  logic                       finish,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [6:0]                 op,
  input  logic [2:0]                 funct3,
  input  logic [6:0]                 funct7,
  input  logic [4:0]                 rd,
  input  logic [4:0]                 rs1,
  input  logic [4:0]                 rs2,
  input  logic [31:0]                imm,
  output logic                       imem_we,
  input  logic                       imem_ready,
  output logic [AW-1:0]              imem_addr,
  output logic [31:0]                imem_wdata,
  output logic                       done,
  output logic [$clog2(MEM_WORDS):0] words,
  output logic                       err_opcode,
  output logic                       err_align,
  output logic                       wrapped
);
  localparam int WW = $clog2(MEM_WORDS) + 1;
  localparam logic [AW-1:0] LIMIT = AW'(MEM_WORDS * 4);
  state_e state_q, state_d;
  logic [AW-1:0] addr_q, addr_d, addr_inc;
  logic [WW-1:0] words_q, words_d;
  logic [31:0] wdata_q, wdata_d, word;
  logic we_q, we_d, eb_q, eb_d, done_q, done_d;
  logic err_opcode_q, err_opcode_d, err_align_q, err_align_d, wrapped_q, wrapped_d;
  logic fmt_bad, free, fire, accept;
  fmt_e fmt;
  inst_pack u_pack (
    .op(op), .funct3(funct3), .funct7(funct7), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .word(word), .fmt_bad(fmt_bad)
  );
  always_comb begin
    free = !we_q || imem_ready;
    fire = we_q && imem_ready;
    in_ready = state_q == RUN && !finish && free;
    accept = in_valid && in_ready;
    fmt = fmt_of(op);
    addr_inc = addr_q + AW'(4);
    state_d = state_q;
    addr_d = addr_q;
    words_d = words_q;
    we_d = we_q && !imem_ready;
    wdata_d = wdata_q;
    eb_d = eb_q;
    done_d = done_q;
    err_opcode_d = err_opcode_q;
    err_align_d = err_align_q;
    wrapped_d = wrapped_q;
    if (fire) begin
      addr_d = addr_inc == LIMIT ? '0 : addr_inc;
      wrapped_d = wrapped_q || addr_inc == LIMIT;
      words_d = words_q + WW'(1);
    end
    if (state_q == RUN && finish) state_d = TERM;
    if (accept && fmt_bad) err_opcode_d = 1'b1;
    if (accept && !fmt_bad) begin
      we_d = 1'b1;
      wdata_d = word;
      err_align_d = err_align_q || ((fmt == FMT_B || fmt == FMT_J) && imm[0]);
    end
    // eb_q marks that EBREAK already sits in the output register
    if (state_q == TERM && !eb_q && free) begin
      we_d = 1'b1;
      wdata_d = EBREAK_WORD;
      eb_d = 1'b1;
    end
    if (state_q == TERM && eb_q && fire) begin
      state_d = DONE;
      done_d = 1'b1;
    end
    if ((state_q == IDLE || state_q == DONE) && start) begin
      state_d = RUN;
      addr_d = base & ~AW'(3);
      words_d = '0;
      eb_d = 1'b0;
      done_d = 1'b0;
      err_opcode_d = 1'b0;
      err_align_d = 1'b0;
      wrapped_d = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q <= '0;
      words_q <= '0;
      wdata_q <= '0;
      we_q <= 1'b0;
      eb_q <= 1'b0;
      done_q <= 1'b0;
      err_opcode_q <= 1'b0;
      err_align_q <= 1'b0;
      wrapped_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      words_q <= words_d;
      wdata_q <= wdata_d;
      we_q <= we_d;
      eb_q <= eb_d;
      done_q <= done_d;
      err_opcode_q <= err_opcode_d;
      err_align_q <= err_align_d;
      wrapped_q <= wrapped_d;
    end
  end
  assign imem_we = we_q;
  assign imem_addr = addr_q;
  assign imem_wdata = wdata_q;
  assign done = done_q;
  assign words = words_q;
  assign err_opcode = err_opcode_q;
  assign err_align = err_align_q;
  assign wrapped = wrapped_q;
endmodule

// File: doc/inst_stream_encoder.md
Name: inst_stream_encoder

Overview:
- Writer-side counterpart of the main decoder: takes decoded instruction fields (opcode, funct3, funct7, rd, rs1, rs2, imm) and packs them into RV32I instruction words.
- Streams the words into instruction memory through its write port, at consecutive word addresses.
- Used by the bench/loader path to build programs in-system and terminates each program with EBREAK, which the core decodes as pause.
- Sequential: 4-state FSM, address and word counters, one-entry output register with valid/ready backpressure on both sides.

Parameters:
- MEM_WORDS, 1024: instruction memory depth in 32-bit words; power of two.
- AW, 32: width of byte address output.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  pulse: begin a program at base
- base  in  AW  byte start address; bits [1:0] ignored (forced 0)
- finish  in  1  pulse: append EBREAK and close program
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid && in_ready
- op  in  7  opcode
- funct3  in  3
- funct7  in  7
- rd, rs1, rs2  in  5 each  register indices
- imm  in  32  sign-extended immediate; U-type uses imm[31:12]
- imem_we  out  1  write valid (output register full)
- imem_ready  in  1  memory accepts write when imem_we && imem_ready
- imem_addr  out  AW  byte address
- imem_wdata  out  32  encoded word
- done  out  1  level; program closed
- words  out  $clog2(MEM_WORDS)+1  words written since start, EBREAK included
- err_opcode  out  1  sticky: unknown opcode seen
- err_align  out  1  sticky: B/J imm[0]=1
- wrapped  out  1  sticky: address wrapped past MEM_WORDS

Behaviour:
- Reset: state IDLE. All outputs 0: in_ready, imem_we, imem_addr, imem_wdata, done, words, all error flags.
- States:
  - IDLE: in_ready=0. start -> RUN; addr<=base&~3; words, errors, done cleared.
  - RUN: in_ready = !finish && (!imem_we || imem_ready).
  - TERM: loads EBREAK (0x00100073) into the output register when free; -> DONE once that write is accepted.
  - DONE: done=1, in_ready=0. start -> RUN (same clears as from IDLE).
- Priority rules:
  - start is ignored in RUN and TERM.
  - finish is ignored outside RUN.
  - finish in RUN: no request is accepted that cycle; next state TERM. A pending write drains first.
- Latency:
  - An accepted request appears on imem_we/imem_wdata/imem_addr on the next cycle.
  - Back-to-back acceptance gives 1 word/cycle when imem_ready=1.
- Backpressure: while imem_we && !imem_ready, imem_wdata and imem_addr are held stable and in_ready=0.
- Write completion (imem_we && imem_ready):
  - addr += 4 and words += 1.
  - When addr reaches MEM_WORDS*4 it becomes 0 and wrapped is set.
  - imem_we clears unless a new word is loaded in the same cycle.
- Encoding, by op:
  - 0110011 -> R-type.
  - I-type: 0010011, 0000011, 1100111, 1110011, 0001111.
  - 0100011 -> S-type.
  - 1100011 -> B-type.
  - 0110111, 0010111 -> U-type.
  - 1101111 -> J-type.
- Field rules:
  - Unused fields (e.g. rd for S/B) are encoded as 0; the input value is don't-care.
  - For 0010011 with funct3=001/101, bits[31:25]=funct7 and bits[24:20]=imm[4:0].
  - 1110011: imm[11:0] carries 0 (ECALL) or 1 (EBREAK).
- Unknown op:
  - The request is accepted and consumed, nothing is written, err_opcode is set, addr and words are unchanged.
  - An unknown op can be accepted while a write is stalled only under the normal in_ready rule.
- B/J with imm[0]=1: err_align is set; the word is still encoded (bit 0 is dropped by the format).
- reset mid-program: immediate return to IDLE. Any in-flight write is dropped (imem_we=0 next cycle).

Decomposition:
- Shared package rv_pkg holds:
  - opcode constants (already defined alongside the decoder);
  - format enum {R,I,S,B,U,J,BAD};
  - EBREAK_WORD;
  - state enum {IDLE,RUN,TERM,DONE}.
- Sub-module inst_pack: purely combinational, (op, fields) -> {word, fmt_bad}. The top module holds the FSM, counters, output register and flags.

Test Plan:
- start base=0x100, issue these, imem_ready=1 -> words at addrs 0x100, 0x104, …:
  - addi x1,x0,5 -> 0x00500093
  - add x3,x1,x2 -> 0x002081B3
  - sub x3,x1,x2 -> 0x402081B3
- Same program, further words:
  - beq x1,x2,+8 -> 0x00208463
  - sw x2,12(x1) -> 0x0020A623
  - lui x5,0x12345 -> 0x123452B7
- finish after 3 words -> EBREAK 0x00100073 written at base+12; done=1; words=4.
- Backpressure: imem_ready=0 for 3 cycles with a word pending -> imem_wdata/imem_addr stable, in_ready=0, words unchanged; write completes in the cycle imem_ready rises.
- op=0x7F, then addi -> err_opcode=1; addi lands at base (no gap); words=1.
- MEM_WORDS=4, base=0xC, two writes -> second at 0x0; wrapped=1. reset during stall -> all outputs 0 next cycle.
